actv_ram_reader: RTL and testbench

- Consumer end of a convolution layer's output-activation RAM and its downstream req/ack handshake.
- When the layer signals that its output activations are complete, this block acknowledges with a 4-phase handshake.
- It then reads NumActv words from its own port of the dual-port activation BRAM and streams them out on a valid/ready interface with a last marker.
- It hides the one-cycle BRAM read latency behind a 2-entry output buffer, so full throughput is kept under backpressure.

---
 rtl/actv_ram_reader.sv | 153 +++++++++++++++
 tb/tb_actv_ram_reader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/actv_ram_reader.sv
// actv_ram_reader: reads a completed output-activation buffer out of a BRAM port
// and streams it on a valid/ready interface with a last marker.
//
// Ports:
//   clk_i, reset_i (async, active-low)
//   req_i / ack_o       4-phase request/acknowledge from the producing layer
//   base_addr_i         first RAM address, sampled in IDLE when req_i=1
//   ready_o             reader idle
//   done_o              one-cycle pulse after the last word is accepted
//   ram_addr_o/ram_we_o/ram_din_i  BRAM read port (1-cycle read latency)
//   m_valid_o/m_ready_i/m_data_o/m_last_o  output stream
//
// Optional: define ACTV_READER_RELU_EN to clamp negative words to zero at buffer write.
module actv_ram_reader #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned DataSizeW = 28,
  parameter int unsigned DataSizeH = 28,
  parameter int unsigned NumActv   = DataSizeW * DataSizeH,
  parameter int unsigned AddrWidth = $clog2(NumActv)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 req_i,
  output logic                 ack_o,
  input  logic [AddrWidth-1:0] base_addr_i,
  output logic                 ready_o,
  output logic                 done_o,
  output logic [AddrWidth-1:0] ram_addr_o,
  output logic                 ram_we_o,
  input  logic [DataWidth-1:0] ram_din_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [DataWidth-1:0] m_data_o,
  output logic                 m_last_o
);

  localparam int unsigned CntWidth = $clog2(NumActv + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_READ, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [CntWidth-1:0]   issue_cnt_q;
  logic [AddrWidth-1:0]  addr_q;
  logic                  inflight_q, inflight_last_q;
  logic [DataWidth-1:0]  buf_data_q [2];
  logic                  buf_last_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;
  logic                  ack_q, ready_q, done_q;

  logic                  issue_c, latch_c, pop_c, is_last_c, has_room_c;
  logic [DataWidth-1:0]  wdata_c;

  assign pop_c     = m_valid_o & m_ready_i;
  assign is_last_c = (issue_cnt_q == CntWidth'(NumActv - 1));
  // A word leaving this cycle frees its slot, so back-to-back reads continue under m_ready_i=1.
  assign has_room_c = (3'(count_q) + 3'(inflight_q) - 3'(pop_c)) < 3'd2;

`ifdef ACTV_READER_RELU_EN
  assign wdata_c = ram_din_i[DataWidth-1] ? '0 : ram_din_i;
`else
  assign wdata_c = ram_din_i;
`endif

  // Next-state and issue decision
  always_comb begin
    state_d = state_q;
    issue_c = 1'b0;
    latch_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          latch_c = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!req_i) state_d = S_READ;
      end
      S_READ: begin
        if (has_room_c) begin
          issue_c = 1'b1;
          if (is_last_c) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // done_q is set by the pop of the last word, so the buffer is empty here.
        if (done_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, read issue and handshake registers
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q         <= S_IDLE;
      issue_cnt_q     <= '0;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      ack_q           <= 1'b0;
      ready_q         <= 1'b1;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      inflight_q      <= issue_c;
      inflight_last_q <= issue_c & is_last_c;
      ack_q           <= (state_d == S_ACK);
      ready_q         <= (state_d == S_IDLE);
      done_q          <= pop_c & buf_last_q[rd_ptr_q];
      if (latch_c) begin
        issue_cnt_q <= '0;
        addr_q      <= base_addr_i;
      end else if (issue_c) begin
        issue_cnt_q <= issue_cnt_q + CntWidth'(1);
        // Hold the final address instead of stepping past the transfer.
        if (!is_last_c) addr_q <= addr_q + AddrWidth'(1);
      end
    end
  end

  // Two-entry output buffer; written the cycle after each read is issued
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_last_q[i] <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (inflight_q) begin
        buf_data_q[wr_ptr_q] <= wdata_c;
        buf_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop_c) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(inflight_q) - 2'(pop_c);
    end
  end

  assign ack_o      = ack_q;
  assign ready_o    = ready_q;
  assign done_o     = done_q;
  assign ram_addr_o = addr_q;
  assign ram_we_o   = 1'b0;
  assign m_valid_o  = (count_q != 2'd0);
  assign m_data_o   = buf_data_q[rd_ptr_q];
  assign m_last_o   = m_valid_o & buf_last_q[rd_ptr_q];

endmodule

// File: tb/tb_actv_ram_reader.sv
// Testbench for actv_ram_reader with a 4x4 feature map (16 words, 4-bit addresses).
module tb_actv_ram_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned N  = 16;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          req_i;
  logic          ack_o;
  logic [AW-1:0] base_addr_i;
  logic          ready_o;
  logic          done_o;
  logic [AW-1:0] ram_addr_o;
  logic          ram_we_o;
  logic [DW-1:0] ram_din_i;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [DW-1:0] m_data_o;
  logic          m_last_o;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] mem [N];

  actv_ram_reader #(
    .DataWidth(DW), .DataSizeW(4), .DataSizeH(4), .NumActv(N), .AddrWidth(AW)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .ack_o(ack_o),
    .base_addr_i(base_addr_i), .ready_o(ready_o), .done_o(done_o),
    .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_din_i(ram_din_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .m_last_o(m_last_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural BRAM: synchronous read, one cycle latency
  always @(posedge clk_i) ram_din_i <= mem[ram_addr_o];

  function automatic logic [DW-1:0] model_word(input logic [DW-1:0] w);
`ifdef ACTV_READER_RELU_EN
    if (w[DW-1]) return '0;
`endif
    return w;
  endfunction

  // One transfer. mode 0: m_ready_i=1 always; mode 1: random backpressure.
  // abort_after>0: assert reset right after that many words are accepted.
  task automatic run_transfer(input int base, input int mode, input int abort_after,
                              input bit check_timing);
    logic [DW-1:0] exp_q[$];
    int n, cyc, acc, off;
    bit expect_done, done_seen, prev_stall;
    logic [DW-1:0] prev_data;
    logic prev_last;
    for (int i = 0; i < int'(N); i++) exp_q.push_back(model_word(mem[(base + i) % N]));

    @(negedge clk_i);
    m_ready_i   = 1'b0;
    base_addr_i = AW'(base);
    req_i       = 1'b1;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!ack_o && n < 20);
    tests_run++;
    if (ack_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL ack_rise timeout: ack_o=%b required 1", ack_o);
      req_i = 1'b0;
      return;
    end
    @(negedge clk_i);
    tests_run++;
    if (ack_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL ack_hold: ack_o=%b required 1 while req_i held", ack_o);
    end
    req_i = 1'b0;
    @(negedge clk_i);
    tests_run++;
    if (ack_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL ack_fall: ack_o=%b required 0 one cycle after req_i fell", ack_o);
    end

    cyc = 1; acc = 0; expect_done = 0; done_seen = 0; prev_stall = 0;
    prev_data = '0; prev_last = 1'b0;
    while (cyc < 200) begin
      tests_run++;
      if (done_o !== expect_done) begin
        tests_failed++;
        $display("FAIL done_pulse: cyc=%0d done_o=%b required %b", cyc, done_o, expect_done);
      end
      if (done_o === 1'b1 && expect_done) begin
        done_seen = 1;
        if (check_timing) begin
          tests_run++;
          if (cyc != int'(N) + 3) begin
            tests_failed++;
            $display("FAIL done_latency: done at cycle %0d required %0d", cyc, N + 3);
          end
        end
        break;
      end
      expect_done = 0;
      if (prev_stall) begin
        tests_run++;
        if (m_valid_o !== 1'b1 || m_data_o !== prev_data || m_last_o !== prev_last) begin
          tests_failed++;
          $display("FAIL stall_stable: valid=%b data=%h last=%b required 1 %h %b",
                   m_valid_o, m_data_o, m_last_o, prev_data, prev_last);
        end
      end
      off = (int'(ram_addr_o) - base + int'(N)) % int'(N);
      tests_run++;
      if (off - acc > 2) begin
        tests_failed++;
        $display("FAIL addr_lead: addr offset %0d accepted %0d required lead <= 2", off, acc);
      end
      m_ready_i = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (m_valid_o === 1'b1 && m_ready_i) begin
        tests_run++;
        if (m_data_o !== exp_q[acc] || m_last_o !== (acc == int'(N) - 1)) begin
          tests_failed++;
          $display("FAIL word %0d: data=%h last=%b required %h %b",
                   acc, m_data_o, m_last_o, exp_q[acc], (acc == int'(N) - 1));
        end
        if (check_timing && mode == 0) begin
          tests_run++;
          if (cyc != 3 + acc) begin
            tests_failed++;
            $display("FAIL word_latency %0d: cycle %0d required %0d", acc, cyc, 3 + acc);
          end
        end
        acc++;
        if (acc == int'(N)) expect_done = 1;
        if (abort_after > 0 && acc == abort_after) begin
          @(negedge clk_i);
          reset_i   = 1'b0;
          m_ready_i = 1'b0;
          #1;
          tests_run++;
          if (m_valid_o !== 1'b0 || ack_o !== 1'b0 || ready_o !== 1'b1 ||
              done_o !== 1'b0 || ram_addr_o !== '0 || m_last_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_clear: valid=%b ack=%b ready=%b done=%b addr=%h last=%b required 0 0 1 0 0 0",
                     m_valid_o, ack_o, ready_o, done_o, ram_addr_o, m_last_o);
          end
          for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            tests_run++;
            if (done_o !== 1'b0) begin
              tests_failed++;
              $display("FAIL abort_no_done: done_o=%b required 0", done_o);
            end
          end
          reset_i = 1'b1;
          for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            tests_run++;
            if (done_o !== 1'b0 || m_valid_o !== 1'b0) begin
              tests_failed++;
              $display("FAIL abort_quiet: done=%b valid=%b required 0 0", done_o, m_valid_o);
            end
          end
          return;
        end
      end
      prev_stall = (m_valid_o === 1'b1) && !m_ready_i;
      prev_data  = m_data_o;
      prev_last  = m_last_o;
      @(negedge clk_i);
      cyc++;
    end
    tests_run++;
    if (!done_seen || acc != int'(N)) begin
      tests_failed++;
      $display("FAIL transfer_end: done_seen=%0d accepted=%0d required 1 %0d", done_seen, acc, N);
    end
    @(negedge clk_i);
    m_ready_i = 1'b0;
    tests_run++;
    if (done_o !== 1'b0 || ready_o !== 1'b1 || m_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_done: done=%b ready=%b valid=%b required 0 1 0", done_o, ready_o, m_valid_o);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b0; req_i = 1'b0; m_ready_i = 1'b0; base_addr_i = '0;
    repeat (3) @(negedge clk_i);
    tests_run++;
    if (ready_o !== 1'b1 || ack_o !== 1'b0 || m_valid_o !== 1'b0 || done_o !== 1'b0 ||
        m_last_o !== 1'b0 || ram_addr_o !== '0 || ram_we_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: ready=%b ack=%b valid=%b done=%b last=%b addr=%h we=%b",
               ready_o, ack_o, m_valid_o, done_o, m_last_o, ram_addr_o, ram_we_o);
    end
    reset_i = 1'b1;
    base_addr_i = 4'd9;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      tests_run++;
      if (ready_o !== 1'b1 || ram_addr_o !== '0 || m_valid_o !== 1'b0 || ack_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle: ready=%b addr=%h valid=%b ack=%b required 1 0 0 0",
                 ready_o, ram_addr_o, m_valid_o, ack_o);
      end
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < int'(N); i++) mem[i] = DW'(i + 1);
    run_transfer(0, 0, 0, 1'b1);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < int'(N); i++) mem[i] = DW'(i + 1);
    run_transfer(0, 1, 0, 1'b0);
    for (int i = 0; i < int'(N); i++) mem[i] = DW'($urandom);
    run_transfer(int'($urandom_range(0, N - 1)), 1, 0, 1'b0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < int'(N); i++) mem[i] = DW'($urandom);
    run_transfer(14, 0, 0, 1'b1);
    run_transfer(14, 1, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < int'(N); i++) mem[i] = DW'(i + 1);
    run_transfer(0, 1, 5, 1'b0);
    run_transfer(0, 0, 0, 1'b1);
  endtask

  task automatic test_relu();
    for (int i = 0; i < int'(N); i++) mem[i] = DW'($urandom);
    mem[0] = 8'h85; mem[1] = 8'h10; mem[2] = 8'hFF;
    run_transfer(0, 0, 0, 1'b1);
    run_transfer(0, 1, 0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < int'(N); i++) mem[i] = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_relu();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
